// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: per-bit synchroniser, optional debounce filter,
// selectable edge capture and a maskable, registered level interrupt.
module pio_in_edge_irq #(
  parameter int               WIDTH           = 8,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 0,
  parameter int               EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } addr_e;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      read_mux;
  logic             cs_write;
  logic             unused_wdata;

  // Upper writedata bits beyond WIDTH are deliberately ignored.
  assign unused_wdata = ^writedata;

  // NOTE: every synchroniser stage is reset so no edge appears on reset release.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_VALUE;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable = sync_out;
    end else begin : g_debounce
      logic [CNT_W-1:0] cnt [WIDTH];
      logic [WIDTH-1:0] stable_q;

      // A bit only follows sync after it has disagreed for D consecutive edges.
      always_ff @(posedge clk) begin
        if (reset) begin
          stable_q <= RESET_VALUE;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync_out[i] == stable_q[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
              stable_q[i] <= sync_out[i];
              cnt[i]      <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
        end
      end

      assign stable = stable_q;
    end
  endgenerate

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_hit = stable & ~prev;
      1:       edge_hit = ~stable & prev;
      default: edge_hit = stable ^ prev;
    endcase
  end

  assign cs_write   = chipselect & write;
  assign clear_bits = (cs_write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA: read_mux = 32'(stable);
      ADDR_RSVD: read_mux = '0;
      ADDR_MASK: read_mux = 32'(irqmask);
      ADDR_EDGE: read_mux = 32'(edgecapture);
      default:   read_mux = '0;
    endcase
  end

  // NOTE: non-blocking updates make a same-cycle read see pre-write state.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev        <= RESET_VALUE;
      irqmask     <= '0;
      edgecapture <= '0;
      irq         <= 1'b0;
      readdata    <= '0;
    end else begin
      prev        <= stable;
      // Set wins over a same-cycle clear.
      edgecapture <= (edgecapture & ~clear_bits) | edge_hit;
      if (cs_write && address == ADDR_MASK) irqmask <= writedata[WIDTH-1:0];
      irq <= |(edgecapture & irqmask);
      if (chipselect && read) readdata <= read_mux;
    end
  end

endmodule
